ntt_bfu_scheduler: RTL
======================

// Module: ntt_bfu_scheduler
// PURPOSE
//  Sequences the butterfly datapath (DigitalTop_v2 wrapper: data1/data2/zeta in, data1/data2/zeta out)
//  over a full in-place NTT or INTT of N coefficients held in a dual-port coefficient RAM.
//  Per stage: issues N/2 butterfly read-address pairs plus twiddle index, tracks pipeline
//  latency, emits matching write-back addresses, drains between stages (RAW hazard), pulses done.
//  Sits between the control/CSR block and the coefficient RAM + zeta ROM + butterfly unit.
// PARAMETERS
//  N          256  transform length, power of two >= 4
//  LOG2N      8    $clog2(N); address width
//  MEM_LAT    1    coefficient RAM / zeta ROM read latency, cycles
//  BFU_LAT    4    butterfly unit latency, cycles (input valid -> output valid)
// PORTS
//  clk_i         in   1      clock, all logic on posedge
//  reset_ni      in   1      asynchronous, active-low reset
//  start_i       in   1      start transform; sampled only in IDLE
//  mode_i        in   1      0 = forward NTT (CT), 1 = inverse INTT (GS); latched at start
//  stall_i       in   1      hold issue this cycle (in-flight ops continue)
//  busy_o        out  1      high from accepted start until done_o cycle inclusive
//  done_o        out  1      one-cycle pulse, transform complete
//  mode_o        out  1      latched mode (selects CT/GS datapath and zeta table)
//  rd_en_o       out  1      read request to RAM/ROM this cycle
//  rd_addr1_o    out  LOG2N  first coefficient address (data1)
//  rd_addr2_o    out  LOG2N  second coefficient address (data2)
//  zeta_addr_o   out  LOG2N  twiddle index into zeta ROM
//  bfu_valid_o   out  1      rd_en_o delayed MEM_LAT; qualifies butterfly inputs
//  wr_en_o       out  1      write-back strobe, rd_en_o delayed L = MEM_LAT+BFU_LAT
//  wr_addr1_o    out  LOG2N  write address for data1_o (rd_addr1_o delayed L)
//  wr_addr2_o    out  LOG2N  write address for data2_o (rd_addr2_o delayed L)
// BEHAVIOUR
//  - Reset: FSM=IDLE, all counters 0, every output 0, delay lines cleared (mid-op reset aborts; no stray wr_en_o).
//  - FSM: IDLE -start_i-> ISSUE; ISSUE -last butterfly of stage issued-> DRAIN;
//    DRAIN -L cycles elapsed-> ISSUE (next stage) or DONE (last stage); DONE -> IDLE (done_o=1 here).
//  - start_i outside IDLE ignored. stall_i in ISSUE: rd_en_o=0, counters hold; ignored in other states.
//  - Counters: stage s in 0..LOG2N-1, butterfly b in 0..N/2-1, one issue per non-stalled ISSUE cycle.
//  - NTT: len = N>>(s+1); INTT: len = 1<<s; lg = log2(len).
//    group = b>>lg, off = b & (len-1); addr1 = (group<<(lg+1)) | off; addr2 = addr1 + len (no wrap, < N).
//  - zeta index: NTT = (1<<s) + group; INTT = (N>>(s+1)) + group  (ROM holds inverse table for mode 1).
//  - Delay lines are fixed-length shift registers, never stalled; wr_* exactly L cycles after rd_*.
//  - DRAIN holds L cycles after last issue so stage s+1 first read follows stage s last write.
//  - No stall: done_o at cycle (N/2)*LOG2N + LOG2N*L + 1 after start accepted; each stall adds 1.
//  - Address/zeta outputs are registered; hold last value when rd_en_o=0.
// STRUCTURE
//  - Package ntt_sched_pkg: state_e enum (IDLE, ISSUE, DRAIN, DONE), mode_e (NTT_CT, INTT_GS),
//    localparam L = MEM_LAT+BFU_LAT helper function addr_gen(s, b, mode).
//  - One sub-module: ntt_delay_line #(WIDTH, DEPTH) used for bfu_valid (DEPTH=MEM_LAT) and
//    {wr_en, wr_addr1, wr_addr2} (DEPTH=L). FSM, counters, address generation in this module.
// TESTING  (N=8, LOG2N=3, MEM_LAT=1, BFU_LAT=4, L=5)
//  - NTT sequence: start, mode=0 -> stage0 pairs (0,4)(1,5)(2,6)(3,7) zeta 1; stage1 (0,2)(1,3) z2,
//    (4,6)(5,7) z3; stage2 (0,1) z4, (2,3) z5, (4,5) z6, (6,7) z7; done_o at cycle 28.
//  - INTT sequence: mode=1 -> stage0 (0,1) z4 .. (6,7) z7; stage1 (0,2) z2 .. (5,7) z3; stage2 (0,4)..(3,7) z1.
//  - Latency/hazard: wr_addr* equals rd_addr* from 5 cycles earlier; no stage s+1 rd_en_o before
//    last stage s wr_en_o + 1 cycle; bfu_valid_o = rd_en_o delayed 1.
//  - Stall: 3 stall_i cycles mid stage1 -> issue order unchanged, done_o at cycle 31, no duplicate addresses.
//  - start_i pulsed while busy -> ignored, single done_o; back-to-back start in cycle after done -> accepted.
//  - Async reset asserted in DRAIN -> all outputs 0 immediately, no wr_en_o after release, next start clean.

Source files
------------

// File: rtl/ntt_sched_pkg.sv
// Shared types and the butterfly address generator for the NTT/INTT scheduler.
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    NTT_CT  = 1'b0,
    INTT_GS = 1'b1
  } mode_e;

  localparam int MEM_LAT_DEF = 1;
  localparam int BFU_LAT_DEF = 4;
  localparam int L           = MEM_LAT_DEF + BFU_LAT_DEF;

  // Widest address the generator produces; callers keep the low LOG2N bits.
  localparam int AW_MAX = 16;

  typedef struct packed {
    logic [AW_MAX-1:0] addr1;
    logic [AW_MAX-1:0] addr2;
    logic [AW_MAX-1:0] zeta;
  } bfly_addr_t;

  // Butterfly b of stage s: forward transform halves the span every stage,
  // inverse transform doubles it. Twiddle index walks the bit-reversed table.
  function automatic bfly_addr_t addr_gen(input int unsigned s,
                                          input int unsigned b,
                                          input mode_e       mode,
                                          input int unsigned log2n);
    int unsigned lg;
    int unsigned len;
    int unsigned grp;
    int unsigned off;
    int unsigned a1;
    int unsigned zb;
    bfly_addr_t  r;
    lg  = (mode == INTT_GS) ? s : (log2n - 32'd1 - s);
    len = 32'd1 << lg;
    grp = b >> lg;
    off = b & (len - 32'd1);
    a1  = (grp << (lg + 32'd1)) | off;
    zb  = (mode == INTT_GS) ? ((32'd1 << log2n) >> (s + 32'd1)) : (32'd1 << s);
    r.addr1 = AW_MAX'(a1);
    r.addr2 = AW_MAX'(a1 + len);
    r.zeta  = AW_MAX'(zb + grp);
    return r;
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-length, never-stalled shift register; clears on reset so no stale
// strobe can escape after an aborted transform.
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift one stage per clock, flush every stage on reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_bfu_scheduler.sv
// Sequences butterfly reads, twiddle indices and matching write-backs over
// all stages of an in-place NTT/INTT, draining the pipeline between stages.
module ntt_bfu_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int N       = 256,
  parameter int LOG2N   = 8,
  parameter int MEM_LAT = 1,
  parameter int BFU_LAT = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mode_o,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr1_o,
  output logic [LOG2N-1:0] rd_addr2_o,
  output logic [LOG2N-1:0] zeta_addr_o,
  output logic             bfu_valid_o,
  output logic             wr_en_o,
  output logic [LOG2N-1:0] wr_addr1_o,
  output logic [LOG2N-1:0] wr_addr2_o
);

  localparam int LAT = MEM_LAT + BFU_LAT;
  localparam int BW  = LOG2N - 1;
  localparam int CW  = $clog2(LAT) + 1;
  localparam int WRW = 2 * LOG2N + 1;

  localparam logic [BW-1:0]    LAST_BFLY  = BW'(N / 2 - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]    LAST_DRAIN = CW'(LAT - 1);

  state_e           state_q;
  mode_e            mode_q;
  logic [LOG2N-1:0] stage_q;
  logic [BW-1:0]    bfly_q;
  logic [CW-1:0]    drain_q;
  bfly_addr_t       ag;
  logic [WRW-1:0]   wr_bus;

  assign mode_o = (mode_q == INTT_GS);

  // Addresses for the butterfly that would be issued this cycle.
  always_comb begin
    ag = addr_gen(32'(stage_q), 32'(bfly_q), mode_q, LOG2N);
  end

  // Main sequencer: state, counters and every registered control output.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      mode_q      <= NTT_CT;
      stage_q     <= '0;
      bfly_q      <= '0;
      drain_q     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr1_o  <= '0;
      rd_addr2_o  <= '0;
      zeta_addr_o <= '0;
    end else begin
      rd_en_o <= 1'b0;
      done_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ISSUE;
            mode_q  <= mode_e'(mode_i);
            stage_q <= '0;
            bfly_q  <= '0;
            drain_q <= '0;
            busy_o  <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        ISSUE: begin
          if (!stall_i) begin
            rd_en_o     <= 1'b1;
            rd_addr1_o  <= ag.addr1[LOG2N-1:0];
            rd_addr2_o  <= ag.addr2[LOG2N-1:0];
            zeta_addr_o <= ag.zeta[LOG2N-1:0];
            if (bfly_q == LAST_BFLY) begin
              bfly_q  <= '0;
              drain_q <= '0;
              state_q <= DRAIN;
            end else begin
              bfly_q <= bfly_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == LAST_DRAIN) begin
            drain_q <= '0;
            if (stage_q == LAST_STAGE) begin
              state_q <= DONE;
            end else begin
              stage_q <= stage_q + 1'b1;
              state_q <= ISSUE;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          done_o  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ntt_delay_line #(
    .WIDTH (1),
    .DEPTH (MEM_LAT)
  ) u_valid_dly (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .din      (rd_en_o),
    .dout     (bfu_valid_o)
  );

  ntt_delay_line #(
    .WIDTH (WRW),
    .DEPTH (LAT)
  ) u_wr_dly (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .din      ({rd_en_o, rd_addr1_o, rd_addr2_o}),
    .dout     (wr_bus)
  );

  assign {wr_en_o, wr_addr1_o, wr_addr2_o} = wr_bus;

endmodule
